ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Execute-stage ALU with integrated EX/MEM pipeline register for the pipelined MIPS core. Sits directly downstream of the ALU control decoder.
- Consumes the 4-bit `alu_ctrl` code together with ID/EX operands.
- Computes the result and registers it, with zero flag, destination and write-enable, into the EX/MEM boundary.
- Handles pipeline stall/flush and raises a one-shot JR redirect.

## Interface
- `DATA_W`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: ID/EX slot holds a real instruction
- `alu_ctrl` in 4: operation code from ALU control
- `op_a` in DATA_W: rs operand (forwarded)
- `op_b` in DATA_W: rt operand or sign-extended immediate
- `shamt` in SHAMT_W: instruction[10:6]
- `dest_in` in 5: destination register number
- `reg_write_in` in 1: write-back enable from main control
- `stall` in 1: hold EX/MEM register
- `flush` in 1: squash EX/MEM register
- `out_valid` out 1: EX/MEM slot valid
- `alu_result` out DATA_W: registered result
- `zero` out 1: registered (result == 0), used by branch-equal
- `dest_out` out 5: registered destination
- `reg_write_out` out 1: registered, qualified write enable
- `jr_taken` out 1: one-cycle redirect pulse
- `jr_target` out DATA_W: redirect address
- `illegal` out 1: registered unknown-opcode flag
- `ovf` out 1: signed-overflow flag (see Configuration)

## Operation
- Code map:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^DATA_W)
  - 0110 SUB (op_a − op_b, wraps)
  - 0111 SLT: signed compare, result 1 or 0 zero-extended
  - 1111 SLL: op_b << shamt, zero fill
  - 1000 JR: result = op_a
- Any other code, including X/Z: result 0, `illegal`=1, `reg_write_out` forced 0.
- JR: `reg_write_out` forced 0. `jr_target` = op_a captured at load.
- Load condition: `!stall && !flush`.
  - Captures `in_valid`, result, zero, dest, write enable (`reg_write_in & in_valid`, then qualified as above), `illegal`, and the JR flag.
- `flush` has priority over `stall`. On flush, `out_valid`, `reg_write_out`, `jr_taken`, `illegal` and `ovf` clear next edge; data fields hold.
- `stall` without flush holds every register unchanged, except `jr_taken`.
- `jr_taken` = JR flag AND `out_valid` AND fresh-load bit.
  - The fresh-load bit is set on a load edge and cleared on any non-load edge.
  - The pulse therefore lasts exactly one cycle even when a stall follows.
- `in_valid`=0 loads a bubble: `out_valid`=0, all side-effect outputs 0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- No combinational input-to-output path.
- Reset (async assert, sync-safe deassert by the top level):
  - `out_valid`, `reg_write_out`, `jr_taken`, `illegal`, `ovf`, `zero`=0
  - `alu_result`, `jr_target`=0
  - `dest_out`=0
- Reset mid-stall or mid-JR drops the pulse and the held instruction immediately.
- Simultaneous stall+flush resolves as flush.

## Configuration
- `EX_ALU_OVF_EN` defined:
  - ADD/SUB signed overflow (operand signs equal, result sign differs; SUB tests op_a vs ~op_b) sets `ovf` for the loaded instruction.
  - The same condition forces `reg_write_out`=0.
- Not defined: `ovf` tied 0; ADD/SUB always write back wrapped result.

## Test plan
- ADD 0x7FFF_FFFF+1, reg_write_in=1: result 0x8000_0000, zero=0.
  - With macro: ovf=1, reg_write_out=0.
  - Without macro: ovf=0, reg_write_out=1.
- SUB 5−5 then SLT −1 vs 1: first result 0, zero=1; next cycle result 1, zero=0.
- SLL op_b=0x0000_0003, shamt=4: result 0x30. Then code 0011: result 0, illegal=1, reg_write_out=0.
- JR op_a=0x0040_0100 loaded, stall held 3 cycles: jr_taken high exactly 1 cycle, jr_target=0x0040_0100 held, reg_write_out=0.
- stall+flush asserted together with valid ADD: next cycle out_valid=0, reg_write_out=0. Release: following instruction loads normally.
- Assert rst_n=0 mid-cycle with out_valid=1: all flags 0 before next clk edge, result 0.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU feeding the EX/MEM pipeline register, with stall/flush control and a one-shot JR redirect.
// Optional feature: define EX_ALU_OVF_EN to flag ADD/SUB signed overflow and suppress their write-back.
module ex_alu_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [4:0]        dest_in,
  input  logic              reg_write_in,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [4:0]        dest_out,
  output logic              reg_write_out,
  output logic              jr_taken,
  output logic [DATA_W-1:0] jr_target,
  output logic              illegal,
  output logic              ovf
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1111;
  localparam logic [3:0] OP_JR  = 4'b1000;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_lt;
  logic              w_illegal;
  logic              w_is_jr;
  logic              w_load;
  logic              w_ovf;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic [4:0]        r_dest;
  logic              r_reg_write;
  logic              r_jr;
  logic              r_fresh;
  logic [DATA_W-1:0] r_jr_target;
  logic              r_illegal;

  assign w_sum  = op_a + op_b;
  assign w_diff = op_a - op_b;
  assign w_lt   = $signed(op_a) < $signed(op_b);
  // Control handshake: a load happens only when neither stall nor flush is asserted; flush wins over stall.
  assign w_load = !stall && !flush;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    w_is_jr   = 1'b0;
    case (alu_ctrl)
      OP_AND: w_result = op_a & op_b;
      OP_OR:  w_result = op_a | op_b;
      OP_ADD: w_result = w_sum;
      OP_SUB: w_result = w_diff;
      OP_SLT: w_result = {{(DATA_W-1){1'b0}}, w_lt};
      OP_SLL: w_result = op_b << shamt;
      OP_JR: begin
        w_result = op_a;
        w_is_jr  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef EX_ALU_OVF_EN
  logic r_ovf;
  // SUB overflows like ADD of op_a and ~op_b: same operand signs, different result sign.
  always_comb begin
    w_ovf = 1'b0;
    if (alu_ctrl == OP_ADD)
      w_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (w_sum[DATA_W-1] != op_a[DATA_W-1]);
    else if (alu_ctrl == OP_SUB)
      w_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (w_diff[DATA_W-1] != op_a[DATA_W-1]);
  end
  assign ovf = r_ovf;
`else
  assign w_ovf = 1'b0;
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_dest      <= '0;
      r_reg_write <= 1'b0;
      r_jr        <= 1'b0;
      r_fresh     <= 1'b0;
      r_jr_target <= '0;
      r_illegal   <= 1'b0;
`ifdef EX_ALU_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_reg_write <= 1'b0;
      r_jr        <= 1'b0;
      r_fresh     <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef EX_ALU_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (!w_load) begin
      // Stalled: hold the slot, but the redirect pulse must not repeat.
      r_fresh <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_result    <= w_result;
      r_zero      <= (w_result == '0);
      r_dest      <= dest_in;
      r_reg_write <= reg_write_in & in_valid & !w_illegal & !w_is_jr & !w_ovf;
      r_jr        <= in_valid & w_is_jr;
      r_fresh     <= 1'b1;
      r_jr_target <= op_a;
      r_illegal   <= in_valid & w_illegal;
`ifdef EX_ALU_OVF_EN
      r_ovf       <= in_valid & w_ovf;
`endif
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_result    = r_result;
  assign zero          = r_zero;
  assign dest_out      = r_dest;
  assign reg_write_out = r_reg_write;
  assign jr_taken      = r_jr & r_out_valid & r_fresh;
  assign jr_target     = r_jr_target;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: each task drives one scenario and checks the EX/MEM outputs inline.
module tb_ex_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [4:0]  dest_in;
  logic        reg_write_in;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  dest_out;
  logic        reg_write_out;
  logic        jr_taken;
  logic [31:0] jr_target;
  logic        illegal;
  logic        ovf;

  int n_tests;
  int n_fail;

`ifdef EX_ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  ex_alu_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .shamt(shamt), .dest_in(dest_in),
    .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
    .dest_out(dest_out), .reg_write_out(reg_write_out), .jr_taken(jr_taken),
    .jr_target(jr_target), .illegal(illegal), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [4:0] d,
                       input logic rw);
    in_valid = v; alu_ctrl = c; op_a = a; op_b = b; shamt = sh; dest_in = d; reg_write_in = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step(); step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", alu_result); end
    n_tests++; if ({zero, reg_write_out, jr_taken, illegal, ovf} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {zero, reg_write_out, jr_taken, illegal, ovf}); end
    n_tests++; if ({dest_out, jr_target} !== 37'h0) begin
      n_fail++; $display("FAIL reset_dest_target got %h/%h exp 0/0", dest_out, jr_target); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_ovf();
    logic exp_rw;
    exp_rw = !OVF_ON;
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd3, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result got %h exp 80000000", alu_result); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b exp 0", zero); end
    n_tests++; if (out_valid !== 1'b1 || dest_out !== 5'd3) begin
      n_fail++; $display("FAIL add_valid_dest got %b/%0d exp 1/3", out_valid, dest_out); end
    n_tests++; if (ovf !== OVF_ON) begin n_fail++; $display("FAIL add_ovf got %b exp %b", ovf, OVF_ON); end
    n_tests++; if (reg_write_out !== exp_rw) begin n_fail++; $display("FAIL add_reg_write got %b exp %b", reg_write_out, exp_rw); end
  endtask

  task automatic test_sub_slt();
    drive(1'b1, 4'b0110, 32'd5, 32'd5, 5'd0, 5'd4, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL sub_result got %h z=%b exp 0 z=1", alu_result, zero); end
    n_tests++; if (reg_write_out !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL sub_rw_ovf got %b/%b exp 1/0", reg_write_out, ovf); end
    drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd5, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h1 || zero !== 1'b0) begin
      n_fail++; $display("FAIL slt_result got %h z=%b exp 1 z=0", alu_result, zero); end
    drive(1'b1, 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL slt_false got %h z=%b exp 0 z=1", alu_result, zero); end
  endtask

  task automatic test_logic_ops();
    drive(1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 5'd6, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h00F0_1200) begin n_fail++; $display("FAIL and_result got %h exp 00f01200", alu_result); end
    drive(1'b1, 4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 5'd6, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'hFFF0_FF34) begin n_fail++; $display("FAIL or_result got %h exp fff0ff34", alu_result); end
    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd6, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0 || reg_write_out !== 1'b1) begin
      n_fail++; $display("FAIL add_wrap got %h z=%b o=%b rw=%b exp 0 z=1 o=0 rw=1", alu_result, zero, ovf, reg_write_out); end
  endtask

  task automatic test_sll_illegal();
    drive(1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0003, 5'd4, 5'd7, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h30 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL sll_result got %h ill=%b exp 30 ill=0", alu_result, illegal); end
    drive(1'b1, 4'b0011, 32'h1234_5678, 32'h0000_0003, 5'd4, 5'd7, 1'b1);
    step();
    n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL illegal_result got %h exp 0", alu_result); end
    n_tests++; if (illegal !== 1'b1 || reg_write_out !== 1'b0) begin
      n_fail++; $display("FAIL illegal_flags got ill=%b rw=%b exp ill=1 rw=0", illegal, reg_write_out); end
  endtask

  task automatic test_jr_stall();
    drive(1'b1, 4'b1000, 32'h0040_0100, 32'h0000_0009, 5'd0, 5'd31, 1'b1);
    step();
    n_tests++; if (jr_taken !== 1'b1) begin n_fail++; $display("FAIL jr_pulse got %b exp 1", jr_taken); end
    n_tests++; if (jr_target !== 32'h0040_0100 || reg_write_out !== 1'b0) begin
      n_fail++; $display("FAIL jr_target_rw got %h/%b exp 00400100/0", jr_target, reg_write_out); end
    stall = 1'b1;
    drive(1'b1, 4'b0010, 32'h1111_1111, 32'h2222_2222, 5'd0, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (jr_taken !== 1'b0) begin n_fail++; $display("FAIL jr_stall_pulse cycle %0d got %b exp 0", i, jr_taken); end
      n_tests++; if (jr_target !== 32'h0040_0100 || alu_result !== 32'h0040_0100 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL jr_stall_hold cycle %0d got %h/%h/%b exp 00400100/00400100/1", i, jr_target, alu_result, out_valid); end
    end
    stall = 1'b0;
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 4'b0010, 32'd2, 32'd3, 5'd0, 5'd8, 1'b1);
    step();
    n_tests++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got v=%b rw=%b exp 0/0", out_valid, reg_write_out); end
    n_tests++; if (alu_result !== 32'h0040_0100 || dest_out !== 5'd31) begin
      n_fail++; $display("FAIL flush_data_hold got %h/%0d exp 00400100/31", alu_result, dest_out); end
    stall = 1'b0; flush = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd5 || reg_write_out !== 1'b1 || dest_out !== 5'd8) begin
      n_fail++; $display("FAIL after_flush got v=%b r=%h rw=%b d=%0d exp 1/5/1/8", out_valid, alu_result, reg_write_out, dest_out); end
  endtask

  task automatic test_bubble();
    drive(1'b0, 4'b1000, 32'h0000_0444, 32'h0, 5'd0, 5'd2, 1'b1);
    step();
    n_tests++; if ({out_valid, reg_write_out, jr_taken, illegal, ovf} !== 5'b0) begin
      n_fail++; $display("FAIL bubble_flags got %b exp 00000", {out_valid, reg_write_out, jr_taken, illegal, ovf}); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd0, 5'd10, 1'b1);
    step();
    n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd2) begin
      n_fail++; $display("FAIL pre_reset got v=%b r=%h exp 1/2", out_valid, alu_result); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({out_valid, reg_write_out, jr_taken, illegal, ovf, zero} !== 6'b0) begin
      n_fail++; $display("FAIL async_reset_flags got %b exp 000000", {out_valid, reg_write_out, jr_taken, illegal, ovf, zero}); end
    n_tests++; if (alu_result !== 32'h0 || dest_out !== 5'd0 || jr_target !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_data got %h/%0d/%h exp 0/0/0", alu_result, dest_out, jr_target); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add_ovf();
    test_sub_slt();
    test_logic_ops();
    test_sll_illegal();
    test_jr_stall();
    test_stall_flush();
    test_bubble();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
